// File: rtl/fp16_pkg.sv
// fp16_pkg: shared binary16 format constants and the unpacked-field view of a value.
// No ports. Imported by mac_unit.
package fp16_pkg;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned BIAS  = 15;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_NINF = 16'hFC00;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

endpackage

// File: rtl/mac_unit_lzc.sv
// lzc: leading-zero counter, used to normalise the post-add magnitude.
// Ports:
//   value  in   Width   vector to scan from the MSB down
//   count  out  CntW    number of leading zeros (Width when value is all zero)
module lzc #(
  parameter int unsigned Width = 26,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] value,
  output logic [CntW-1:0]  count
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    count = CntW'(Width);
    for (int i = 0; i < Width; i++) begin
      if (value[i]) count = CntW'(Width - 1 - i);
    end
  end

endmodule

// File: rtl/mac_unit.sv
// mac_unit: fused binary16 multiply-accumulate, mac_out = in_a * in_b + in_c, one rounding
// (nearest-even), subnormals flushed to zero, result registered once.
// Ports:
//   clk      in   1   clock, rising edge
//   rst      in   1   synchronous active-high reset, clears mac_out
//   in_a     in   16  multiplicand
//   in_b     in   16  multiplier
//   in_c     in   16  addend
//   mac_out  out 16   registered result of the inputs sampled on the previous edge
module mac_unit
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [15:0] in_c,
  output logic [15:0] mac_out
);

  fp16_t a, b, c;
  assign a = fp16_t'(in_a);
  assign b = fp16_t'(in_b);
  assign c = fp16_t'(in_c);

  // Unpack
  logic a_zero, b_zero, c_zero, a_inf, b_inf, c_inf, a_nan, b_nan, c_nan;
  assign a_zero = (a.exp == '0);
  assign b_zero = (b.exp == '0);
  assign c_zero = (c.exp == '0);
  assign a_inf  = (a.exp == '1) && (a.man == '0);
  assign b_inf  = (b.exp == '1) && (b.man == '0);
  assign c_inf  = (c.exp == '1) && (c.man == '0);
  assign a_nan  = (a.exp == '1) && (a.man != '0);
  assign b_nan  = (b.exp == '1) && (b.man != '0);
  assign c_nan  = (c.exp == '1) && (c.man != '0);

  logic p_sign, p_zero, p_inf;
  assign p_sign = a.sign ^ b.sign;
  assign p_zero = a_zero | b_zero;
  assign p_inf  = a_inf | b_inf;

  // Multiply: exact 22-bit product, then normalised so both addends are 1.xxx with the binary
  // point below bit 21. This makes exponent-then-significand comparison a true magnitude order.
  logic [21:0]       prod_raw, prod_sig, c_sig;
  logic signed [9:0] exp_p, exp_c;
  assign prod_raw = 22'({1'b1, a.man}) * 22'({1'b1, b.man});
  assign prod_sig = prod_raw[21] ? prod_raw : {prod_raw[20:0], 1'b0};
  assign exp_p    = 10'(a.exp) + 10'(b.exp) - 10'(BIAS) + 10'(prod_raw[21]);
  // A zero addend sinks below any product so alignment turns it into nothing.
  assign c_sig    = c_zero ? '0 : {1'b1, c.man, 11'b0};
  assign exp_c    = c_zero ? -10'sd64 : 10'(c.exp);

  // Align and add: 22-bit significand plus 3 guard bits, sticky folded into the LSB.
  logic              p_big, s_big, eff_sub;
  logic signed [9:0] e_big, diff;
  logic [21:0]       sig_big, sig_small;
  logic [5:0]        shamt;
  logic [49:0]       small_wide;
  logic [25:0]       big_ext, small_ext, sum;

  always_comb begin
    p_big     = (exp_p > exp_c) || ((exp_p == exp_c) && (prod_sig >= c_sig));
    e_big     = p_big ? exp_p : exp_c;
    diff      = p_big ? (exp_p - exp_c) : (exp_c - exp_p);
    sig_big   = p_big ? prod_sig : c_sig;
    sig_small = p_big ? c_sig : prod_sig;
    s_big     = p_big ? p_sign : c.sign;
    eff_sub   = p_sign ^ c.sign;
    // Beyond 25 every bit of the smaller operand already lands in the sticky half.
    shamt      = (diff > 10'sd25) ? 6'd25 : diff[5:0];
    small_wide = {sig_small, 28'b0} >> shamt;
    big_ext    = {1'b0, sig_big, 3'b0};
    small_ext  = {1'b0, small_wide[49:26], small_wide[25] | (|small_wide[24:0])};
    sum        = eff_sub ? (big_ext - small_ext) : (big_ext + small_ext);
  end

  // Normalise: hidden bit lands at bit 25 of the shifted sum (dropped), weight 2^1 at lz=0.
  logic [4:0]        lz;
  logic [24:0]       norm;
  logic signed [9:0] e_norm, e_fin;
  logic              round_up;
  logic [10:0]       mant_rnd;

  lzc #(
    .Width(26)
  ) u_lzc (
    .value(sum),
    .count(lz)
  );

  assign norm     = 25'(sum << lz);
  assign e_norm   = e_big + 10'sd1 - $signed({5'b0, lz});
  assign round_up = norm[14] & ((|norm[13:0]) | norm[15]);
  // Carry into bit 10 means the mantissa rolled over to 1.0 of the next binade.
  assign mant_rnd = {1'b0, norm[24:15]} + 11'(round_up);
  assign e_fin    = e_norm + $signed({9'b0, mant_rnd[10]});

  // Specials and packing, highest priority first.
  logic [15:0] result_d;

  always_comb begin
    result_d = '0;
    if (a_nan | b_nan | c_nan | (a_inf & b_zero) | (b_inf & a_zero) |
        (p_inf & c_inf & (p_sign != c.sign))) begin
      result_d = FP16_QNAN;
    end else if (p_inf) begin
      result_d = p_sign ? FP16_NINF : FP16_PINF;
    end else if (c_inf) begin
      result_d = in_c;
    end else if (p_zero) begin
      // Zero product passes c through; two zeros keep a minus sign only if both carry it.
      result_d = c_zero ? {p_sign & c.sign, 15'b0} : in_c;
    end else if (sum == '0) begin
      result_d = '0;
    end else if (e_fin >= 10'sd31) begin
      result_d = {s_big, 15'h7C00};
    end else if (e_fin <= 10'sd0) begin
      result_d = {s_big, 15'b0};
    end else begin
      result_d = {s_big, e_fin[4:0], mant_rnd[9:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mac_out <= '0;
    else     mac_out <= result_d;
  end

endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit: directed checks of the fp16 fused MAC plus a streamed run against an exact
// integer reference model.
module tb_mac_unit;

  logic        clk;
  logic        rst;
  logic [15:0] in_a, in_b, in_c;
  logic [15:0] mac_out;

  int n_cmp = 0;
  int n_err = 0;

  mac_unit dut (
    .clk(clk),
    .rst(rst),
    .in_a(in_a),
    .in_b(in_b),
    .in_c(in_c),
    .mac_out(mac_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {a, b, c, expected}
  localparam logic [63:0] BASIC_V [3] = '{
    64'h3C00_4000_3C00_4200,
    64'h4000_4000_BC00_4200,
    64'h3E00_3E00_3800_4180
  };
  localparam logic [63:0] CANCEL_V [5] = '{
    64'h3C00_3C00_BC00_0000,
    64'h0000_4000_C200_C200,
    64'h8000_3C00_8000_8000,
    64'h0000_3C00_0000_0000,
    64'h3C01_3C01_BC00_1800
  };
  localparam logic [63:0] SPECIAL_V [9] = '{
    64'h7BFF_4000_0000_7C00,
    64'h7C00_0000_0000_7E00,
    64'h7C00_3C00_FC00_7E00,
    64'h7E01_3C00_0000_7E00,
    64'h7C00_3C00_7C00_7C00,
    64'hFC00_3C00_0000_FC00,
    64'h3C00_3C00_FC00_FC00,
    64'h0400_0400_0000_0000,
    64'h8400_0400_0000_8000
  };
  localparam logic [63:0] ROUND_V [3] = '{
    64'h1000_3C00_3C00_3C00,
    64'h1000_3C00_3C01_3C02,
    64'h7BFF_3C00_4C00_7C00
  };
  // {a, b, c}
  localparam logic [47:0] STREAM_V [10] = '{
    48'h4000_4200_3C00, 48'hC000_3C00_4000, 48'h3555_4248_B800, 48'h5640_D3A0_6000,
    48'h2E66_3266_0001, 48'h7000_7000_0000, 48'h0400_3800_0000, 48'h3C00_1000_3C00,
    48'h4E00_C500_5A00, 48'h1234_5678_9ABC
  };

  // Exact reference: both terms as integers in units of 2^-48, summed, then rounded once.
  function automatic logic [15:0] fma_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
    logic az, bz, cz, ai, bi, ci, an, bn, cn, sp, sc, neg, rb, st;
    int ea, eb, ec, k, e;
    logic signed [127:0] p, q, s;
    logic [127:0] mag;
    logic [11:0] m;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ec = int'(c[14:10]);
    az = (ea == 0);
    bz = (eb == 0);
    cz = (ec == 0);
    ai = (ea == 31) && (a[9:0] == 10'd0);
    bi = (eb == 31) && (b[9:0] == 10'd0);
    ci = (ec == 31) && (c[9:0] == 10'd0);
    an = (ea == 31) && (a[9:0] != 10'd0);
    bn = (eb == 31) && (b[9:0] != 10'd0);
    cn = (ec == 31) && (c[9:0] != 10'd0);
    sp = a[15] ^ b[15];
    sc = c[15];
    if (an || bn || cn || (ai && bz) || (bi && az) || ((ai || bi) && ci && (sp != sc)))
      return 16'h7E00;
    if (ai || bi) return sp ? 16'hFC00 : 16'h7C00;
    if (ci) return c;
    if (az || bz) return cz ? {sp & sc, 15'h0000} : c;
    p = 128'({1'b1, a[9:0]});
    p = p * 128'({1'b1, b[9:0]});
    p = p << (ea + eb - 2);
    q = cz ? 128'sd0 : (128'({1'b1, c[9:0]}) << (ec + 23));
    s = (sp ? -p : p) + (sc ? -q : q);
    if (s == 128'sd0) return 16'h0000;
    neg = (s < 128'sd0);
    mag = neg ? -s : s;
    k = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) k = i;
    if (k >= 11) begin
      m  = 12'(mag >> (k - 10));
      rb = mag[k - 11];
      st = (mag & ((128'd1 << (k - 11)) - 128'd1)) != 128'd0;
    end else begin
      m  = 12'(mag << (10 - k));
      rb = 1'b0;
      st = 1'b0;
    end
    if (rb && (st || m[0])) m = m + 12'd1;
    e = k - 33;
    if (m[11]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 31) return {neg, 15'h7C00};
    if (e <= 0) return {neg, 15'h0000};
    return {neg, e[4:0], m[9:0]};
  endfunction

  task automatic test_reset();
    rst  = 1'b1;
    in_a = 16'h4000;
    in_b = 16'h4000;
    in_c = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (mac_out !== 16'h0000) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h expected 0000", i, mac_out);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (mac_out !== 16'h4400) begin
      n_err++;
      $display("FAIL reset_release: got %h expected 4400", mac_out);
    end
  endtask

  task automatic test_basic();
    logic [63:0] v;
    for (int i = 0; i < 3; i++) begin
      v = BASIC_V[i];
      in_a = v[63:48];
      in_b = v[47:32];
      in_c = v[31:16];
      @(posedge clk);
      #1;
      n_cmp++;
      if (mac_out !== v[15:0]) begin
        n_err++;
        $display("FAIL basic[%0d]: got %h expected %h", i, mac_out, v[15:0]);
      end
    end
  endtask

  task automatic test_cancel_zero();
    logic [63:0] v;
    for (int i = 0; i < 5; i++) begin
      v = CANCEL_V[i];
      in_a = v[63:48];
      in_b = v[47:32];
      in_c = v[31:16];
      @(posedge clk);
      #1;
      n_cmp++;
      if (mac_out !== v[15:0]) begin
        n_err++;
        $display("FAIL cancel_zero[%0d]: got %h expected %h", i, mac_out, v[15:0]);
      end
    end
  endtask

  task automatic test_specials();
    logic [63:0] v;
    for (int i = 0; i < 9; i++) begin
      v = SPECIAL_V[i];
      in_a = v[63:48];
      in_b = v[47:32];
      in_c = v[31:16];
      @(posedge clk);
      #1;
      n_cmp++;
      if (mac_out !== v[15:0]) begin
        n_err++;
        $display("FAIL specials[%0d]: got %h expected %h", i, mac_out, v[15:0]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [63:0] v;
    for (int i = 0; i < 3; i++) begin
      v = ROUND_V[i];
      in_a = v[63:48];
      in_b = v[47:32];
      in_c = v[31:16];
      @(posedge clk);
      #1;
      n_cmp++;
      if (mac_out !== v[15:0]) begin
        n_err++;
        $display("FAIL rounding[%0d]: got %h expected %h", i, mac_out, v[15:0]);
      end
    end
  endtask

  task automatic test_latency();
    in_a = 16'h3C00;
    in_b = 16'h4000;
    in_c = 16'h3C00;
    @(posedge clk);
    #1;
    in_a = 16'h4000;
    in_b = 16'h4000;
    in_c = 16'h0000;
    #3;
    n_cmp++;
    if (mac_out !== 16'h4200) begin
      n_err++;
      $display("FAIL latency_hold: got %h expected 4200", mac_out);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (mac_out !== 16'h4400) begin
      n_err++;
      $display("FAIL latency_update: got %h expected 4400", mac_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] v;
    logic [15:0] expv;
    for (int i = 0; i < 10; i++) begin
      v = STREAM_V[i];
      in_a = v[47:32];
      in_b = v[31:16];
      in_c = v[15:0];
      expv = fma_model(v[47:32], v[31:16], v[15:0]);
      @(posedge clk);
      #1;
      n_cmp++;
      if (mac_out !== expv) begin
        n_err++;
        $display("FAIL stream[%0d] a=%h b=%h c=%h: got %h expected %h",
                 i, v[47:32], v[31:16], v[15:0], mac_out, expv);
      end
    end
  endtask

  task automatic test_reset_midstream();
    in_a = 16'h4000;
    in_b = 16'h4000;
    in_c = 16'h3C00;
    @(posedge clk);
    #1;
    n_cmp++;
    if (mac_out !== 16'h4500) begin
      n_err++;
      $display("FAIL pre_reset: got %h expected 4500", mac_out);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (mac_out !== 16'h0000) begin
      n_err++;
      $display("FAIL midstream_reset: got %h expected 0000", mac_out);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    in_a = '0;
    in_b = '0;
    in_c = '0;
    test_reset();
    test_basic();
    test_cancel_zero();
    test_specials();
    test_rounding();
    test_latency();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
